// File: rtl/uart_tx_fifo_if.sv
// Write-side bundle of the buffered UART transmitter.
// master: producer pushing bytes; slave: the transmitter FIFO.
interface uart_tx_fifo_if #(
    parameter int AW = 4
);
    logic          i_WR_En;
    logic [7:0]    i_WR_Data;
    logic          o_Full;
    logic          o_Empty;
    logic [AW:0]   o_Count;
    logic          o_Ovf;

    modport master (
        output i_WR_En, i_WR_Data,
        input  o_Full, o_Empty, o_Count, o_Ovf
    );

    modport slave (
        input  i_WR_En, i_WR_Data,
        output o_Full, o_Empty, o_Count, o_Ovf
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Buffered UART byte transmitter: DEPTH-byte FIFO feeding an 8N1 serializer.
// Ports: clk, rst (async, active-high); i_TXD_Baud baud select (0..4, 5-7=115200);
//   wr (slave): i_WR_En/i_WR_Data write port, o_Full/o_Empty/o_Count/o_Ovf status;
//   o_TXD_Tx serial line, o_TXD_State frame busy, o_TXD_Done end-of-frame pulse.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit before stop.
module uart_tx_fifo #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int DEPTH    = 16,
    parameter int AW       = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [2:0]     i_TXD_Baud,
    uart_tx_fifo_if.slave  wr,
    output logic           o_TXD_Tx,
    output logic           o_TXD_State,
    output logic           o_TXD_Done
);

    localparam logic [12:0] RLD0 = 13'(CLK_FREQ / 9600 - 1);
    localparam logic [12:0] RLD1 = 13'(CLK_FREQ / 19200 - 1);
    localparam logic [12:0] RLD2 = 13'(CLK_FREQ / 38400 - 1);
    localparam logic [12:0] RLD3 = 13'(CLK_FREQ / 57600 - 1);
    localparam logic [12:0] RLD4 = 13'(CLK_FREQ / 115200 - 1);
    localparam logic [AW:0] FULL_C = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    // Bit period minus one for a baud code.
    function automatic logic [12:0] reload_of(input logic [2:0] code);
        logic [12:0] r;
        unique case (code)
            3'd0:    r = RLD0;
            3'd1:    r = RLD1;
            3'd2:    r = RLD2;
            3'd3:    r = RLD3;
            default: r = RLD4;
        endcase
        return r;
    endfunction

    // FIFO storage and pointers
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          full_q, full_d;
    logic          empty_q, empty_d;
    logic          ovf_q, ovf_d;
    logic          pop;
    logic          wr_acc;

    // Serializer state
    state_t        state_q;
    logic [7:0]    shift_q;
    logic [2:0]    baud_q;
    logic [12:0]   bcnt_q;
    logic [2:0]    idx_q;
    logic [2:0]    idx_nx;
    logic          tx_q;
    logic          busy_q;
    logic          done_q;
    logic [12:0]   reload;

    // Pop only when the count register already shows data, so a write
    // into an empty FIFO is sent on the following IDLE evaluation.
    assign pop    = (state_q == S_IDLE) && !empty_q;
    assign wr_acc = wr.i_WR_En && (!full_q || pop);
    assign idx_nx = idx_q + 3'd1;
    assign reload = reload_of(baud_q);

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        if (wr_acc) wptr_d = wptr_q + 1'b1;
        if (pop)    rptr_d = rptr_q + 1'b1;
        unique case ({wr_acc, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        full_d  = (cnt_d == FULL_C);
        empty_d = (cnt_d == '0);
        ovf_d   = wr.i_WR_En && full_q && !pop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            cnt_q   <= cnt_d;
            full_q  <= full_d;
            empty_q <= empty_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage needs no reset; pointers define what is valid.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wptr_q] <= wr.i_WR_Data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            baud_q  <= '0;
            bcnt_q  <= '0;
            idx_q   <= '0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    tx_q   <= 1'b1;
                    busy_q <= 1'b0;
                    if (!empty_q) begin
                        shift_q <= mem_q[rptr_q];
                        baud_q  <= i_TXD_Baud;
                        bcnt_q  <= reload_of(i_TXD_Baud);
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (bcnt_q == '0) begin
                        bcnt_q  <= reload;
                        idx_q   <= '0;
                        tx_q    <= shift_q[0];
                        state_q <= S_DATA;
                    end else begin
                        bcnt_q <= bcnt_q - 1'b1;
                    end
                end
                S_DATA: begin
                    if (bcnt_q == '0) begin
                        bcnt_q <= reload;
                        if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_q    <= ^shift_q;
                            state_q <= S_PARITY;
`else
                            tx_q    <= 1'b1;
                            state_q <= S_STOP;
`endif
                        end else begin
                            idx_q <= idx_nx;
                            tx_q  <= shift_q[idx_nx];
                        end
                    end else begin
                        bcnt_q <= bcnt_q - 1'b1;
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bcnt_q == '0) begin
                        bcnt_q  <= reload;
                        tx_q    <= 1'b1;
                        state_q <= S_STOP;
                    end else begin
                        bcnt_q <= bcnt_q - 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (bcnt_q == '0) begin
                        tx_q    <= 1'b1;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        bcnt_q <= bcnt_q - 1'b1;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign wr.o_Full    = full_q;
    assign wr.o_Empty   = empty_q;
    assign wr.o_Count   = cnt_q;
    assign wr.o_Ovf     = ovf_q;
    assign o_TXD_Tx     = tx_q;
    assign o_TXD_State  = busy_q;
    assign o_TXD_Done   = done_q;

endmodule
